// File: rtl/uart_pkg.sv
// uart_pkg -- shared definitions for the oversampling UART receiver.
//   uart_state_e    : receiver FSM state encoding
//   DS_*            : data_size codes (5..8 data bits)
//   PAR_*           : parity_mode codes
//   ENTRY_W         : receive FIFO entry width, {break, frame, parity, data[7:0]}
//   maj3            : 2-of-3 majority vote
//   parity_expected : expected parity bit for a mode and a data word
//   last_bit_idx    : index of the final data bit for a data_size code
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } uart_state_e;

  localparam logic [1:0] DS_5BIT = 2'b00;
  localparam logic [1:0] DS_6BIT = 2'b01;
  localparam logic [1:0] DS_7BIT = 2'b10;
  localparam logic [1:0] DS_8BIT = 2'b11;

  localparam logic [1:0] PAR_SPACE = 2'b00;
  localparam logic [1:0] PAR_MARK  = 2'b01;
  localparam logic [1:0] PAR_EVEN  = 2'b10;
  localparam logic [1:0] PAR_ODD   = 2'b11;

  localparam int unsigned ENTRY_W = 11;

  // Error flags pushed for a break condition: break and frame set, parity clear.
  localparam logic [2:0] ERR_BREAK = 3'b110;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Unreceived upper data bits are held at 0, so XOR over all 8 bits is exact.
  function automatic logic parity_expected(input logic [1:0] mode, input logic [7:0] data);
    logic p;
    case (mode)
      PAR_SPACE: p = 1'b0;
      PAR_MARK:  p = 1'b1;
      PAR_EVEN:  p = ^data;
      PAR_ODD:   p = ~(^data);
      default:   p = 1'b0;
    endcase
    return p;
  endfunction

  function automatic logic [2:0] last_bit_idx(input logic [1:0] ds);
    logic [2:0] idx;
    case (ds)
      DS_5BIT: idx = 3'd4;
      DS_6BIT: idx = 3'd5;
      DS_7BIT: idx = 3'd6;
      DS_8BIT: idx = 3'd7;
      default: idx = 3'd7;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo -- first-word-fall-through synchronous FIFO with a registered head.
//   clk, rst_n  : clock, synchronous active-low reset
//   wr_en_i     : push request (dropped when full unless a pop happens in the same cycle)
//   wr_data_i   : word to push
//   rd_en_i     : pop request (ignored while empty)
//   rd_data_o   : head word, 0 when empty
//   valid_o     : FIFO non-empty
//   full_o      : FIFO holds DEPTH words
//   level_o     : number of words held
module uart_sync_fifo #(
  parameter int unsigned WIDTH = 11,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     rd_en_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic                     valid_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             valid_q;
  logic             full_s, pop_s, push_s;

  assign full_s = (count_q == LW'(DEPTH));
  assign pop_s  = rd_en_i & (count_q != {LW{1'b0}});
  // A pop frees the slot in the same cycle, so a full FIFO still accepts a push.
  assign push_s = wr_en_i & (~full_s | pop_s);

  // Next pointers, occupancy and head word.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    head_d   = {WIDTH{1'b0}};
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + LW'(1);
      2'b01:   count_d = count_q - LW'(1);
      default: count_d = count_q;
    endcase
    // The new head is the incoming word when it lands in the slot being exposed.
    if (count_d == {LW{1'b0}}) begin
      head_d = {WIDTH{1'b0}};
    end else if (push_s && (wr_ptr_q == rd_ptr_d)) begin
      head_d = wr_data_i;
    end else begin
      head_d = mem_q[rd_ptr_d];
    end
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  // Pointer, occupancy and registered output state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {LW{1'b0}};
      head_q   <= {WIDTH{1'b0}};
      valid_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
      valid_q  <= (count_d != {LW{1'b0}});
    end
  end

  assign rd_data_o = head_q;
  assign valid_o   = valid_q;
  assign full_o    = full_s;
  assign level_o   = count_q;

endmodule

// File: rtl/uart_rx_os.sv
// uart_rx_os -- oversampling UART receiver with a receive FIFO.
//   clk, rst_n        : clock, synchronous active-low reset
//   rx                : asynchronous serial input, idles high
//   baud_div          : oversample tick period minus one, in clk cycles
//   data_size         : 00=5, 01=6, 10=7, 11=8 data bits
//   parity_en         : parity bit present
//   parity_mode       : 11=odd, 10=even, 01=mark, 00=space
//   stop_bit_size     : 0=1 stop bit, 1=2 stop bits
//   m_data, m_err     : FIFO head word and its {break, frame, parity} flags
//   m_valid, m_ready  : FIFO non-empty / pop the head
//   fifo_level        : number of words held
//   overrun, clr_overrun : sticky lost-word flag and its clear
//   busy              : receiver FSM not idle
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned DIV_W      = 16,
  parameter int unsigned OS_RATE    = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rx,
  input  logic [DIV_W-1:0]              baud_div,
  input  logic [1:0]                    data_size,
  input  logic                          parity_en,
  input  logic [1:0]                    parity_mode,
  input  logic                          stop_bit_size,
  output logic [7:0]                    m_data,
  output logic [2:0]                    m_err,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overrun,
  input  logic                          clr_overrun,
  output logic                          busy
);

  localparam int unsigned OSW = $clog2(OS_RATE);
  localparam logic [OSW-1:0] CNT_S0  = OSW'(OS_RATE / 2 - 1);
  localparam logic [OSW-1:0] CNT_S1  = OSW'(OS_RATE / 2);
  localparam logic [OSW-1:0] CNT_S2  = OSW'(OS_RATE / 2 + 1);
  localparam logic [OSW-1:0] CNT_END = OSW'(OS_RATE - 1);

  logic                sync1_q, sync2_q, rx_prev_q;
  logic [DIV_W-1:0]    tick_cnt_q;
  uart_state_e         state_q;
  logic [OSW-1:0]      os_cnt_q;
  logic [OSW-1:0]      hi_cnt_q;
  logic [1:0]          samp_q;
  logic [2:0]          bit_cnt_q;
  logic                stop_cnt_q;
  logic [7:0]          data_q;
  logic                par_err_q, frm_err_q, all_zero_q;
  logic [1:0]          ds_q, pmode_q;
  logic                pen_q, stop2_q;
  logic                push_q;
  logic [ENTRY_W-1:0]  push_entry_q;
  logic                busy_q;
  logic                overrun_q;

  logic                tick_s, rx_fall_s, start_det_s;
  logic                vote_now_s, bit_end_s, vote_s;
  logic                fifo_full_s, fifo_pop_s, fifo_valid_s;
  logic [ENTRY_W-1:0]  fifo_head_s;

  // Two-flop synchroniser plus edge-detect history. The history flop resets
  // low so a fresh high must be seen after reset before a start is accepted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      rx_prev_q <= 1'b0;
    end else begin
      sync1_q   <= rx;
      sync2_q   <= sync1_q;
      rx_prev_q <= sync2_q;
    end
  end

  assign rx_fall_s   = rx_prev_q & ~sync2_q;
  assign start_det_s = (state_q == ST_IDLE) & rx_fall_s;
  assign tick_s      = (tick_cnt_q == baud_div);

  // Oversample tick divider, re-phased to the detected start edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tick_cnt_q <= {DIV_W{1'b0}};
    end else if (start_det_s || tick_s) begin
      tick_cnt_q <= {DIV_W{1'b0}};
    end else begin
      tick_cnt_q <= tick_cnt_q + DIV_W'(1);
    end
  end

  assign vote_now_s = tick_s & (os_cnt_q == CNT_S2);
  assign bit_end_s  = tick_s & (os_cnt_q == CNT_END);
  // The third sample is taken live on the voting tick.
  assign vote_s     = maj3(samp_q[0], samp_q[1], sync2_q);

  // Receiver FSM with its counters, shift data, flags and push request.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      os_cnt_q     <= {OSW{1'b0}};
      hi_cnt_q     <= {OSW{1'b0}};
      samp_q       <= 2'b00;
      bit_cnt_q    <= 3'd0;
      stop_cnt_q   <= 1'b0;
      data_q       <= 8'h00;
      par_err_q    <= 1'b0;
      frm_err_q    <= 1'b0;
      all_zero_q   <= 1'b0;
      ds_q         <= DS_8BIT;
      pen_q        <= 1'b0;
      pmode_q      <= PAR_SPACE;
      stop2_q      <= 1'b0;
      push_q       <= 1'b0;
      push_entry_q <= {ENTRY_W{1'b0}};
      busy_q       <= 1'b0;
    end else begin
      push_q <= 1'b0;
      if (tick_s && (os_cnt_q == CNT_S0)) samp_q[0] <= sync2_q;
      if (tick_s && (os_cnt_q == CNT_S1)) samp_q[1] <= sync2_q;
      if (start_det_s) begin
        os_cnt_q <= {OSW{1'b0}};
      end else if (tick_s) begin
        os_cnt_q <= (os_cnt_q == CNT_END) ? {OSW{1'b0}} : os_cnt_q + OSW'(1);
      end

      case (state_q)
        ST_IDLE: begin
          if (start_det_s) begin
            state_q    <= ST_START;
            busy_q     <= 1'b1;
            ds_q       <= data_size;
            pen_q      <= parity_en;
            pmode_q    <= parity_mode;
            stop2_q    <= stop_bit_size;
            data_q     <= 8'h00;
            par_err_q  <= 1'b0;
            frm_err_q  <= 1'b0;
            all_zero_q <= 1'b1;
            bit_cnt_q  <= 3'd0;
            stop_cnt_q <= 1'b0;
          end
        end
        ST_START: begin
          if (vote_now_s && vote_s) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (bit_end_s) begin
            state_q <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (vote_now_s) begin
            data_q[bit_cnt_q] <= vote_s;
            if (vote_s) all_zero_q <= 1'b0;
          end
          if (bit_end_s) begin
            if (bit_cnt_q == last_bit_idx(ds_q)) begin
              state_q <= pen_q ? ST_PARITY : ST_STOP;
            end else begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
            end
          end
        end
        ST_PARITY: begin
          if (vote_now_s) begin
            if (vote_s != parity_expected(pmode_q, data_q)) par_err_q <= 1'b1;
            if (vote_s) all_zero_q <= 1'b0;
          end
          if (bit_end_s) state_q <= ST_STOP;
        end
        ST_STOP: begin
          if (vote_now_s) begin
            if (!stop_cnt_q && all_zero_q && !vote_s) begin
              // Line held low through the whole frame: report a break.
              push_q       <= 1'b1;
              push_entry_q <= {ERR_BREAK, 8'h00};
              hi_cnt_q     <= {OSW{1'b0}};
              state_q      <= ST_BREAK;
            end else if (stop_cnt_q == stop2_q) begin
              push_q       <= 1'b1;
              push_entry_q <= {1'b0, frm_err_q | ~vote_s, par_err_q, data_q};
              state_q      <= ST_IDLE;
              busy_q       <= 1'b0;
            end else if (!vote_s) begin
              frm_err_q <= 1'b1;
            end
          end
          if (bit_end_s) stop_cnt_q <= 1'b1;
        end
        ST_BREAK: begin
          if (tick_s) begin
            if (!sync2_q) begin
              hi_cnt_q <= {OSW{1'b0}};
            end else if (hi_cnt_q == CNT_END) begin
              hi_cnt_q <= {OSW{1'b0}};
              state_q  <= ST_IDLE;
              busy_q   <= 1'b0;
            end else begin
              hi_cnt_q <= hi_cnt_q + OSW'(1);
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign fifo_pop_s = fifo_valid_s & m_ready;

  // Sticky overrun: a push into a full FIFO without a pop; a new event beats the clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overrun_q <= 1'b0;
    end else if (push_q && fifo_full_s && !fifo_pop_s) begin
      overrun_q <= 1'b1;
    end else if (clr_overrun) begin
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= overrun_q;
    end
  end

  uart_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (push_q),
    .wr_data_i (push_entry_q),
    .rd_en_i   (m_ready),
    .rd_data_o (fifo_head_s),
    .valid_o   (fifo_valid_s),
    .full_o    (fifo_full_s),
    .level_o   (fifo_level)
  );

  assign m_data  = fifo_head_s[7:0];
  assign m_err   = fifo_head_s[10:8];
  assign m_valid = fifo_valid_s;
  assign overrun = overrun_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed testbench for uart_rx_os: baud_div=4, OS_RATE=16 (80 clk per bit), FIFO_DEPTH=4.
module tb_uart_rx_os;

  logic        clk;
  logic        rst_n;
  logic        rx;
  logic [15:0] baud_div;
  logic [1:0]  data_size;
  logic        parity_en;
  logic [1:0]  parity_mode;
  logic        stop_bit_size;
  logic [7:0]  m_data;
  logic [2:0]  m_err;
  logic        m_valid;
  logic        m_ready;
  logic [2:0]  fifo_level;
  logic        overrun;
  logic        clr_overrun;
  logic        busy;

  int n_checks;
  int n_fail;

  localparam int BIT_CLK = 80;

  uart_rx_os #(
    .FIFO_DEPTH (4),
    .DIV_W      (16),
    .OS_RATE    (16)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rx            (rx),
    .baud_div      (baud_div),
    .data_size     (data_size),
    .parity_en     (parity_en),
    .parity_mode   (parity_mode),
    .stop_bit_size (stop_bit_size),
    .m_data        (m_data),
    .m_err         (m_err),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .fifo_level    (fifo_level),
    .overrun       (overrun),
    .clr_overrun   (clr_overrun),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (BIT_CLK) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input int nb, input logic pen,
                            input logic pbit, input logic s1, input logic s2,
                            input logic two_stop);
    drive_bit(1'b0);
    for (int i = 0; i < nb; i++) drive_bit(d[i]);
    if (pen) drive_bit(pbit);
    drive_bit(s1);
    if (two_stop) drive_bit(s2);
    rx = 1'b1;
  endtask

  task automatic pop_one();
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid: got %b expected 0", m_valid); end
    n_checks++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL reset_level: got %0d expected 0", fifo_level); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (m_data !== 8'h00) begin n_fail++; $display("FAIL reset_m_data: got %h expected 00", m_data); end
    n_checks++; if (m_err !== 3'b000) begin n_fail++; $display("FAIL reset_m_err: got %b expected 000", m_err); end
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  // 8N1 0xA5; config inputs are changed after the start bit and must be ignored.
  // Falling edge at negedge t: detected at t+2.5, stop vote at t+772.5, FIFO write at t+773.5.
  task automatic test_8n1();
    logic [7:0] d;
    d = 8'hA5;
    data_size = 2'b11; parity_en = 1'b0; parity_mode = 2'b00; stop_bit_size = 1'b0;
    drive_bit(1'b0);
    data_size = 2'b00; parity_en = 1'b1; stop_bit_size = 1'b1;
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    rx = 1'b1;
    repeat (52) @(negedge clk);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL 8n1_busy_before_vote: got %b expected 1", busy); end
    n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL 8n1_valid_before_vote: got %b expected 0", m_valid); end
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL 8n1_busy_after_vote: got %b expected 0", busy); end
    n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL 8n1_valid_at_vote: got %b expected 0", m_valid); end
    @(negedge clk);
    n_checks++; if (m_valid !== 1'b1) begin n_fail++; $display("FAIL 8n1_valid_rise: got %b expected 1", m_valid); end
    n_checks++; if (m_data !== 8'hA5) begin n_fail++; $display("FAIL 8n1_data: got %h expected a5", m_data); end
    n_checks++; if (m_err !== 3'b000) begin n_fail++; $display("FAIL 8n1_err: got %b expected 000", m_err); end
    n_checks++; if (fifo_level !== 3'd1) begin n_fail++; $display("FAIL 8n1_level: got %0d expected 1", fifo_level); end
    repeat (40) @(negedge clk);
    pop_one();
    n_checks++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL 8n1_pop_level: got %0d expected 0", fifo_level); end
    n_checks++; if (m_data !== 8'h00) begin n_fail++; $display("FAIL 8n1_empty_data: got %h expected 00", m_data); end
    data_size = 2'b11; parity_en = 1'b0; stop_bit_size = 1'b0;
  endtask

  // 7E2 0x35: four ones, so even parity is 0; send 1 (wrong) and a low second stop bit.
  task automatic test_7e2();
    data_size = 2'b10; parity_en = 1'b1; parity_mode = 2'b10; stop_bit_size = 1'b1;
    send_frame(8'h35, 7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    repeat (40) @(negedge clk);
    n_checks++; if (fifo_level !== 3'd1) begin n_fail++; $display("FAIL 7e2_level: got %0d expected 1", fifo_level); end
    n_checks++; if (m_data !== 8'h35) begin n_fail++; $display("FAIL 7e2_data: got %h expected 35", m_data); end
    n_checks++; if (m_err !== 3'b011) begin n_fail++; $display("FAIL 7e2_err: got %b expected 011", m_err); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL 7e2_busy: got %b expected 0", busy); end
    pop_one();
  endtask

  // 5-bit mark parity: only bits [4:0] of 0x35 (0x15) are sent, parity bit 1 is correct.
  task automatic test_5bit_mark();
    data_size = 2'b00; parity_en = 1'b1; parity_mode = 2'b01; stop_bit_size = 1'b0;
    send_frame(8'h35, 5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    repeat (40) @(negedge clk);
    n_checks++; if (m_data !== 8'h15) begin n_fail++; $display("FAIL 5m1_data: got %h expected 15", m_data); end
    n_checks++; if (m_err !== 3'b000) begin n_fail++; $display("FAIL 5m1_err: got %b expected 000", m_err); end
    n_checks++; if (fifo_level !== 3'd1) begin n_fail++; $display("FAIL 5m1_level: got %0d expected 1", fifo_level); end
    pop_one();
  endtask

  task automatic test_false_start();
    logic saw_busy;
    saw_busy = 1'b0;
    data_size = 2'b11; parity_en = 1'b0; stop_bit_size = 1'b0;
    rx = 1'b0;
    repeat (15) @(negedge clk);
    rx = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy) saw_busy = 1'b1;
    end
    n_checks++; if (saw_busy !== 1'b1) begin n_fail++; $display("FAIL false_start_busy_pulse: got %b expected 1", saw_busy); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL false_start_busy_end: got %b expected 0", busy); end
    n_checks++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL false_start_level: got %0d expected 0", fifo_level); end
  endtask

  // 8O1 break: line low for 12 bits, then busy clears after 16 high ticks (~78 clk).
  task automatic test_break();
    data_size = 2'b11; parity_en = 1'b1; parity_mode = 2'b11; stop_bit_size = 1'b0;
    rx = 1'b0;
    repeat (12 * BIT_CLK) @(negedge clk);
    n_checks++; if (fifo_level !== 3'd1) begin n_fail++; $display("FAIL break_level: got %0d expected 1", fifo_level); end
    n_checks++; if (m_data !== 8'h00) begin n_fail++; $display("FAIL break_data: got %h expected 00", m_data); end
    n_checks++; if (m_err !== 3'b110) begin n_fail++; $display("FAIL break_err: got %b expected 110", m_err); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL break_busy_low: got %b expected 1", busy); end
    rx = 1'b1;
    repeat (70) @(negedge clk);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL break_busy_early: got %b expected 1", busy); end
    repeat (20) @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL break_busy_exit: got %b expected 0", busy); end
    n_checks++; if (fifo_level !== 3'd1) begin n_fail++; $display("FAIL break_single_entry: got %0d expected 1", fifo_level); end
    pop_one();
    parity_en = 1'b0; parity_mode = 2'b00;
  endtask

  // Five back-to-back 8N1 words into a 4-deep FIFO with m_ready low.
  task automatic test_overrun();
    logic [7:0] words [5];
    words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33; words[3] = 8'h44; words[4] = 8'h55;
    data_size = 2'b11; parity_en = 1'b0; stop_bit_size = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send_frame(words[i], 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      if (i == 3) begin
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_not_yet: got %b expected 0", overrun); end
        n_checks++; if (fifo_level !== 3'd4) begin n_fail++; $display("FAIL ovr_level_full: got %0d expected 4", fifo_level); end
      end
    end
    repeat (40) @(negedge clk);
    n_checks++; if (fifo_level !== 3'd4) begin n_fail++; $display("FAIL ovr_level: got %0d expected 4", fifo_level); end
    n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_set: got %b expected 1", overrun); end
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (m_data !== words[i]) begin n_fail++; $display("FAIL ovr_word%0d: got %h expected %h", i, m_data, words[i]); end
      pop_one();
    end
    n_checks++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL ovr_drained: got %0d expected 0", fifo_level); end
    n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_sticky: got %b expected 1", overrun); end
    clr_overrun = 1'b1;
    @(negedge clk);
    clr_overrun = 1'b0;
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_clear: got %b expected 0", overrun); end
  endtask

  // Reset during a data bit of 0x5A, then a clean 0x3C frame.
  task automatic test_reset_mid_frame();
    logic [7:0] d;
    d = 8'h5A;
    data_size = 2'b11; parity_en = 1'b0; stop_bit_size = 1'b0;
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(d[i]);
    rx = d[3];
    repeat (20) @(negedge clk);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rstmid_busy_before: got %b expected 1", busy); end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10 * BIT_CLK) @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy_after: got %b expected 0", busy); end
    n_checks++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL rstmid_no_entry: got %0d expected 0", fifo_level); end
    send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    repeat (40) @(negedge clk);
    n_checks++; if (fifo_level !== 3'd1) begin n_fail++; $display("FAIL rstmid_next_level: got %0d expected 1", fifo_level); end
    n_checks++; if (m_data !== 8'h3C) begin n_fail++; $display("FAIL rstmid_next_data: got %h expected 3c", m_data); end
    n_checks++; if (m_err !== 3'b000) begin n_fail++; $display("FAIL rstmid_next_err: got %b expected 000", m_err); end
    pop_one();
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    rst_n         = 1'b0;
    rx            = 1'b1;
    baud_div      = 16'd4;
    data_size     = 2'b11;
    parity_en     = 1'b0;
    parity_mode   = 2'b00;
    stop_bit_size = 1'b0;
    m_ready       = 1'b0;
    clr_overrun   = 1'b0;
    @(negedge clk);
    test_reset();
    test_8n1();
    test_7e2();
    test_5bit_mark();
    test_false_start();
    test_break();
    test_overrun();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_os.md
UART_RX_OS -- requirements
Module: uart_rx_os

Interface
REQ-001 Parameter FIFO_DEPTH, 8, receive FIFO entries; power of two, 2..256.
REQ-002 Parameter DIV_W, 16, width of the baud divisor.
REQ-003 Parameter OS_RATE, 16, oversample ticks per bit; even, 8..32.
REQ-004 clk  input  1  single clock; all logic on the rising edge.
REQ-005 rst_n  input  1  reset; synchronous, active-low.
REQ-006 rx  input  1  asynchronous serial line; idles high.
REQ-007 baud_div  input  DIV_W  oversample tick period minus one, in clk cycles.
REQ-008 data_size  input  2  data bits per frame: 00=5, 01=6, 10=7, 11=8.
REQ-009 parity_en  input  1  parity bit present.
REQ-010 parity_mode  input  2  parity type: 11=odd, 10=even, 01=mark, 00=space.
REQ-011 stop_bit_size  input  1  stop bits: 0=1, 1=2.
REQ-012 m_data  output  8  head word, LSB-justified; unused upper bits are 0.
REQ-013 m_err  output  3  head flags {break, frame, parity}.
REQ-014 m_valid  output  1  FIFO non-empty.
REQ-015 m_ready  input  1  head pops on any cycle where m_valid & m_ready.
REQ-016 fifo_level  output  $clog2(FIFO_DEPTH)+1  number of entries held.
REQ-017 overrun  output  1  sticky; a word was lost to a full FIFO.
REQ-018 clr_overrun  input  1  single-cycle clear of overrun.
REQ-019 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-020 rx shall pass a 2-flop synchroniser before any use; this adds 2 clk of latency.
REQ-021 Tick generator: one-clk tick every baud_div+1 clk (baud_div=0 ticks every clk); the counter restarts at 0 on start-edge detection.
REQ-022 FSM states: IDLE, START, DATA, PARITY, STOP, BREAK; sample counter counts ticks 0..OS_RATE-1 within each bit.
REQ-023 IDLE -> START on a synchronised rx falling edge; data_size, parity_en, parity_mode and stop_bit_size are latched at this point, and changes mid-frame are ignored.
REQ-024 Each bit value is the majority vote of the samples at counts OS_RATE/2-1, OS_RATE/2 and OS_RATE/2+1.
REQ-025 START: a voted 1 is a false start -> return to IDLE, no push; a voted 0 -> DATA at the end of the bit period.
REQ-026 DATA: shift in LSB-first for the latched 5..8 bits, then go to PARITY if parity_en, else STOP.
REQ-027 PARITY: expected bit = parity_mode[0] XOR (parity_mode[1] AND XOR of data bits); a mismatch sets the parity flag.
REQ-028 STOP: vote each of the 1 or 2 stop bits; any voted 0 sets the frame flag.
REQ-029 Push the 11-bit entry {flags, data} one clk after the final stop-bit vote (at mid-bit), and return to IDLE in the same cycle.
REQ-030 Break: if all data bits, the parity bit (when enabled) and the first stop bit vote 0, push data=0 with break=1 and frame=1, then go to BREAK.
REQ-031 BREAK: stay until synchronised rx has been high for OS_RATE consecutive ticks, then go to IDLE.
REQ-032 FIFO is first-word-fall-through: m_valid, m_data and m_err are valid the clk after a push into an empty FIFO.
REQ-033 Push while full and no pop: discard the word, leave contents unchanged, set overrun the next clk.
REQ-034 Push and pop in the same cycle (including when full): both occur, level is unchanged, no overrun.
REQ-035 A pop on an empty FIFO is ignored; pointers wrap modulo FIFO_DEPTH.
REQ-036 clr_overrun coinciding with a new overrun event: overrun stays 1 (set wins).

Reset
REQ-037 When rst_n is sampled low: state=IDLE, counters 0, FIFO empty, m_valid 0, fifo_level 0, overrun 0, busy 0, m_data 0, m_err 0, synchroniser flops 1.
REQ-038 Reset mid-frame aborts the frame, and the partial word is never pushed; after release, start detection requires a synchronised high followed by a falling edge.

Structure
REQ-039 Package uart_pkg holds the FSM state encoding, data_size and parity_mode codes, and the FIFO entry width (11).
REQ-040 The FIFO is sub-module uart_sync_fifo (parameters WIDTH and DEPTH; ports clk and rst_n); all other logic is inline.

Verification
REQ-041 baud_div=4, OS_RATE=16 (80 clk/bit), 8N1, send 0xA5 -> m_data=0xA5, m_err=000, m_valid rises one clk after the stop-bit vote.
REQ-042 7E2, send 0x35 with an inverted parity bit and the second stop bit 0 -> m_data=0x35, m_err=011.
REQ-043 IDLE, rx low for 15 clk (3 ticks) -> false start, busy pulses, no push, fifo_level stays 0.
REQ-044 8O1, rx held 0 for 12 bit periods, then released -> one entry, data 0x00, m_err=110; busy stays high until rx has been high for 80 clk.
REQ-045 FIFO_DEPTH=4, m_ready=0, send 5 words -> fifo_level=4, overrun=1, words 1-4 read back intact; clr_overrun -> overrun 0.
REQ-046 rst_n low during DATA of 0x5A -> no entry; the next frame 0x3C is received correctly.
